// File: rtl/sm_dmem_bus.sv
// Data-memory responder for schoolMIPS: word RAM plus an I/O window with GPIO and an optional compare timer.
// Define SM_DMEM_TIMER_EN to build the timer (TCNT/TCMP/TCTRL, TSTAT.match, irq).
module sm_dmem_bus #(
  parameter int RAM_AW = 6,
  parameter int GPIO_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dmAddr,
  input  logic              dmWe,
  input  logic [31:0]       dmWData,
  output logic [31:0]       dmRData,
  input  logic [GPIO_W-1:0] gpioIn,
  output logic [GPIO_W-1:0] gpioOut,
  output logic              irq
);

  localparam logic [3:0] RegionRam  = 4'h0;
  localparam logic [3:0] RegionIo   = 4'hF;
  localparam logic [3:0] SelGpioOut = 4'd0;
  localparam logic [3:0] SelGpioIn  = 4'd1;
  localparam logic [3:0] SelTstat   = 4'd5;
`ifdef SM_DMEM_TIMER_EN
  localparam logic [3:0] SelTcnt    = 4'd2;
  localparam logic [3:0] SelTcmp    = 4'd3;
  localparam logic [3:0] SelTctrl   = 4'd4;
`endif

  logic              isRam;
  logic              isIo;
  logic              isUnmapped;
  logic [3:0]        ioSel;
  logic [RAM_AW-1:0] ramIdx;
  logic              ioWrite;
  logic              tstatWrite;

  assign isRam      = (dmAddr[31:28] == RegionRam);
  assign isIo       = (dmAddr[31:28] == RegionIo);
  assign isUnmapped = !isRam && !isIo;
  assign ioSel      = dmAddr[5:2];
  assign ramIdx     = dmAddr[RAM_AW+1:2];
  assign ioWrite    = dmWe && isIo;
  assign tstatWrite = ioWrite && (ioSel == SelTstat);

  // Address bits that are aliased away by the decode.
  logic unusedBits;
`ifdef SM_DMEM_TIMER_EN
  assign unusedBits = ^{dmAddr[27:RAM_AW+2], dmAddr[1:0]};
`else
  assign unusedBits = ^{dmAddr[27:RAM_AW+2], dmAddr[1:0], dmWData[31:GPIO_W]};
`endif

  logic [31:0] ram [1 << RAM_AW];

  // RAM keeps its contents across reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (dmWe && isRam && !rst)
      ram[ramIdx] <= dmWData;
  end

  logic [GPIO_W-1:0] gpioOutReg;
  logic [GPIO_W-1:0] gpioSync1;
  logic [GPIO_W-1:0] gpioSync2;
  logic              errFlag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpioOutReg <= '0;
      gpioSync1  <= '0;
      gpioSync2  <= '0;
    end else begin
      gpioSync1 <= gpioIn;
      gpioSync2 <= gpioSync1;
      if (ioWrite && (ioSel == SelGpioOut))
        gpioOutReg <= dmWData[GPIO_W-1:0];
    end
  end

  // A fresh unmapped access wins over a same-cycle W1C clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      errFlag <= 1'b0;
    else if (isUnmapped)
      errFlag <= 1'b1;
    else if (tstatWrite && dmWData[1])
      errFlag <= 1'b0;
  end

  assign gpioOut = gpioOutReg;

`ifdef SM_DMEM_TIMER_EN
  logic [31:0] tcnt;
  logic [31:0] tcmp;
  logic [2:0]  tctrl;
  logic        matchFlag;
  logic        hit;

  assign hit = tctrl[0] && (tcnt == tcmp);

  // CPU writes to TCNT override counting; a new match overrides a W1C clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt      <= '0;
      tcmp      <= '0;
      tctrl     <= '0;
      matchFlag <= 1'b0;
    end else begin
      if (ioWrite && (ioSel == SelTcnt))
        tcnt <= dmWData;
      else if (hit && tctrl[1])
        tcnt <= '0;
      else if (tctrl[0])
        tcnt <= tcnt + 32'd1;
      if (ioWrite && (ioSel == SelTcmp))
        tcmp <= dmWData;
      if (ioWrite && (ioSel == SelTctrl))
        tctrl <= dmWData[2:0];
      if (hit)
        matchFlag <= 1'b1;
      else if (tstatWrite && dmWData[0])
        matchFlag <= 1'b0;
    end
  end

  assign irq = matchFlag && tctrl[2];
`else
  assign irq = 1'b0;
`endif

  logic [31:0] ioData;

  always_comb begin
    ioData = '0;
    case (ioSel)
      SelGpioOut: ioData = 32'(gpioOutReg);
      SelGpioIn:  ioData = 32'(gpioSync2);
`ifdef SM_DMEM_TIMER_EN
      SelTcnt:    ioData = tcnt;
      SelTcmp:    ioData = tcmp;
      SelTctrl:   ioData = {29'b0, tctrl};
      SelTstat:   ioData = {30'b0, errFlag, matchFlag};
`else
      SelTstat:   ioData = {30'b0, errFlag, 1'b0};
`endif
      default:    ioData = '0;
    endcase
  end

  always_comb begin
    dmRData = '0;
    if (isRam)
      dmRData = ram[ramIdx];
    else if (isIo)
      dmRData = ioData;
  end

endmodule

// File: tb/tb_sm_dmem_bus.sv
// Self-checking bench for sm_dmem_bus: vector table, hand-written timer/reset sequences and a random run against a model.
// Timer sections are active when SM_DMEM_TIMER_EN is defined.
module tb_sm_dmem_bus;

  localparam logic [31:0] A_GPIO_OUT = 32'hF000_0000;
  localparam logic [31:0] A_GPIO_IN  = 32'hF000_0004;
  localparam logic [31:0] A_TCNT     = 32'hF000_0008;
  localparam logic [31:0] A_TCMP     = 32'hF000_000C;
  localparam logic [31:0] A_TCTRL    = 32'hF000_0010;
  localparam logic [31:0] A_TSTAT    = 32'hF000_0014;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dmAddr;
  logic        dmWe;
  logic [31:0] dmWData;
  logic [31:0] dmRData;
  logic [15:0] gpioIn;
  logic [15:0] gpioOut;
  logic        irq;

  always #5 clk = ~clk;

  sm_dmem_bus #(.RAM_AW(6), .GPIO_W(16)) dut (
    .clk(clk), .rst(rst), .dmAddr(dmAddr), .dmWe(dmWe), .dmWData(dmWData),
    .dmRData(dmRData), .gpioIn(gpioIn), .gpioOut(gpioOut), .irq(irq)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: plain state variables updated from the register-map rules.
  logic [31:0] mRam [int];
  logic [15:0] mGpioOut;
  logic [15:0] mGpioHist [$];
  logic [31:0] mCnt, mCmp;
  logic [2:0]  mCtrl;
  logic        mMatch, mErr;

  function automatic void modelReset();
    mGpioOut = '0;
    mGpioHist.delete();
    mCnt = '0; mCmp = '0; mCtrl = '0; mMatch = 1'b0; mErr = 1'b0;
  endfunction

  function automatic void modelEdge();
    logic [3:0] region = dmAddr[31:28];
    int sel = int'((dmAddr >> 2) & 32'd15);
    bit io = (region == 4'hF);
    bit inRam = (region == 4'h0);
    bit wrIo = dmWe && io;
`ifdef SM_DMEM_TIMER_EN
    bit running = mCtrl[0];
    bit hitNow = running && (mCnt == mCmp);
    logic [31:0] nCnt = mCnt;
    bit nMatch = mMatch;
    if (running) nCnt = (hitNow && mCtrl[1]) ? 32'd0 : mCnt + 32'd1;
    if (wrIo && sel == 2) nCnt = dmWData;
    if (hitNow) nMatch = 1'b1;
    else if (wrIo && sel == 5 && dmWData[0]) nMatch = 1'b0;
    if (wrIo && sel == 3) mCmp = dmWData;
    if (wrIo && sel == 4) mCtrl = dmWData[2:0];
    mCnt = nCnt;
    mMatch = nMatch;
`endif
    if (!inRam && !io) mErr = 1'b1;
    else if (wrIo && sel == 5 && dmWData[1]) mErr = 1'b0;
    if (wrIo && sel == 0) mGpioOut = dmWData[15:0];
    if (dmWe && inRam) mRam[int'((dmAddr >> 2) & 32'd63)] = dmWData;
    mGpioHist.push_front(gpioIn);
    if (mGpioHist.size() > 2) void'(mGpioHist.pop_back());
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a, output bit known);
    int idx = int'((a >> 2) & 32'd63);
    int sel = int'((a >> 2) & 32'd15);
    known = 1'b1;
    if (a[31:28] == 4'h0) begin
      if (mRam.exists(idx)) return mRam[idx];
      known = 1'b0;
      return '0;
    end
    if (a[31:28] != 4'hF) return '0;
    case (sel)
      0: return {16'b0, mGpioOut};
      1: return (mGpioHist.size() >= 2) ? {16'b0, mGpioHist[1]} : 32'd0;
`ifdef SM_DMEM_TIMER_EN
      2: return mCnt;
      3: return mCmp;
      4: return {29'b0, mCtrl};
      5: return {30'b0, mErr, mMatch};
`else
      5: return {30'b0, mErr, 1'b0};
`endif
      default: return '0;
    endcase
  endfunction

  function automatic logic modelIrq();
`ifdef SM_DMEM_TIMER_EN
    return mMatch && mCtrl[2];
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one bus cycle (inputs mid-cycle), advance the model and the DUT by one edge.
  task automatic applyStimulus(input logic [31:0] a, input logic we, input logic [31:0] wd);
    dmAddr = a; dmWe = we; dmWData = wd;
    modelEdge();
    @(posedge clk);
    #1;
    dmWe = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a);
    dmAddr = a; dmWe = 1'b0;
    #1;
  endtask

  task automatic checkModel(input string tag);
    bit known;
    logic [31:0] exp = modelRead(dmAddr, known);
    if (known) checkOutput({tag, " rdata"}, dmRData, exp);
    checkOutput({tag, " gpioOut"}, {16'b0, gpioOut}, {16'b0, mGpioOut});
    checkOutput({tag, " irq"}, {31'b0, irq}, {31'b0, modelIrq()});
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] expRData;
    logic [15:0] expGpio;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'h0000};
    vecs[1]  = '{32'h0000_0110, 1'b0, 32'h0,         32'hDEAD_BEEF, 16'h0000};
    vecs[2]  = '{A_GPIO_OUT,    1'b1, 32'h1234_ABCD, 32'h0000_ABCD, 16'hABCD};
    vecs[3]  = '{A_GPIO_IN,     1'b1, 32'hFFFF_FFFF, 32'h0,         16'hABCD};
    vecs[4]  = '{32'hF000_0018, 1'b1, 32'hFFFF_FFFF, 32'h0,         16'hABCD};
    vecs[5]  = '{32'hF000_003C, 1'b1, 32'hFFFF_FFFF, 32'h0,         16'hABCD};
    vecs[6]  = '{32'h0000_0FFC, 1'b1, 32'h0000_0001, 32'h0000_0001, 16'hABCD};
    vecs[7]  = '{32'h0FFF_FFFC, 1'b0, 32'h0,         32'h0000_0001, 16'hABCD};
    vecs[8]  = '{32'h0000_0020, 1'b1, 32'hAAAA_5555, 32'hAAAA_5555, 16'hABCD};
    vecs[9]  = '{A_TSTAT,       1'b0, 32'h0,         32'h0,         16'hABCD};
    vecs[10] = '{32'hF000_0040, 1'b0, 32'h0,         32'h0000_ABCD, 16'hABCD};
    vecs[11] = '{A_GPIO_OUT,    1'b1, 32'hFFFF_0000, 32'h0,         16'h0000};
    vecs[12] = '{A_GPIO_OUT,    1'b1, 32'h0000_5A5A, 32'h0000_5A5A, 16'h5A5A};

    // Reset state
    rst = 1'b1; dmAddr = A_GPIO_OUT; dmWe = 1'b0; dmWData = '0; gpioIn = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset gpioOut", {16'b0, gpioOut}, 32'h0);
    checkOutput("reset irq", {31'b0, irq}, 32'h0);
    peek(A_TCNT);   checkOutput("reset TCNT", dmRData, 32'h0);
    peek(A_TSTAT);  checkOutput("reset TSTAT", dmRData, 32'h0);
    peek(A_GPIO_IN); checkOutput("reset GPIO_IN", dmRData, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    modelEdge();

    $display("[TB] vector table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].wdata);
      checkOutput($sformatf("vec%0d rdata", i), dmRData, vecs[i].expRData);
      checkOutput($sformatf("vec%0d gpioOut", i), {16'b0, gpioOut}, {16'b0, vecs[i].expGpio});
    end

    $display("[TB] GPIO input synchronizer");
    gpioIn = 16'h00A5;
    applyStimulus(A_GPIO_IN, 1'b0, 32'h0);
    checkOutput("gpioIn after 1 edge", dmRData, 32'h0);
    applyStimulus(A_GPIO_IN, 1'b0, 32'h0);
    checkOutput("gpioIn after 2 edges", dmRData, 32'h0000_00A5);

    $display("[TB] unmapped access");
    applyStimulus(32'h0000_0000, 1'b1, 32'h1111_1111);
    dmAddr = 32'h8000_0000; dmWe = 1'b1; dmWData = 32'h2222_2222;
    #1;
    checkOutput("unmapped read", dmRData, 32'h0);
    applyStimulus(32'h8000_0000, 1'b1, 32'h2222_2222);
    applyStimulus(A_TSTAT, 1'b0, 32'h0);
    checkOutput("TSTAT.err set", dmRData, 32'h2);
    applyStimulus(32'h0000_0000, 1'b0, 32'h0);
    checkOutput("unmapped write dropped", dmRData, 32'h1111_1111);
    applyStimulus(A_TSTAT, 1'b1, 32'h2);
    checkOutput("TSTAT.err W1C", dmRData, 32'h0);

`ifdef SM_DMEM_TIMER_EN
    $display("[TB] timer one-shot");
    applyStimulus(A_TCNT, 1'b1, 32'h0);
    applyStimulus(A_TCMP, 1'b1, 32'd5);
    applyStimulus(A_TCTRL, 1'b1, 32'h5);
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(A_TCNT, 1'b0, 32'h0);
      checkOutput($sformatf("oneshot TCNT k=%0d", k), dmRData, 32'(k));
      checkOutput($sformatf("oneshot irq k=%0d", k), {31'b0, irq}, (k >= 6) ? 32'd1 : 32'd0);
    end
    applyStimulus(A_TSTAT, 1'b1, 32'h1);
    checkOutput("irq after W1C", {31'b0, irq}, 32'h0);

    $display("[TB] TCNT write collision");
    applyStimulus(A_TCTRL, 1'b1, 32'h0);
    applyStimulus(A_TCMP, 1'b1, 32'hFFFF_0000);
    applyStimulus(A_TCNT, 1'b1, 32'd50);
    applyStimulus(A_TCTRL, 1'b1, 32'h1);
    applyStimulus(A_TCNT, 1'b1, 32'd100);
    checkOutput("TCNT write beats increment", dmRData, 32'd100);
    applyStimulus(A_TCNT, 1'b0, 32'h0);
    checkOutput("TCNT after write", dmRData, 32'd101);

    $display("[TB] autoreload");
    applyStimulus(A_TCTRL, 1'b1, 32'h0);
    applyStimulus(A_TSTAT, 1'b1, 32'h3);
    applyStimulus(A_TCNT, 1'b1, 32'h0);
    applyStimulus(A_TCMP, 1'b1, 32'd3);
    applyStimulus(A_TCTRL, 1'b1, 32'h3);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(A_TCNT, 1'b0, 32'h0);
      checkOutput($sformatf("autoreload TCNT step %0d", k), dmRData, 32'((k + 1) % 4));
    end
    applyStimulus(A_TSTAT, 1'b0, 32'h0);
    checkOutput("autoreload match sticky", dmRData, 32'h1);
    checkOutput("autoreload irq masked", {31'b0, irq}, 32'h0);
    applyStimulus(A_TCNT, 1'b0, 32'h0);
    applyStimulus(A_TCNT, 1'b0, 32'h0);
    checkOutput("TCNT before collision", dmRData, 32'd3);
    applyStimulus(A_TSTAT, 1'b1, 32'h1);
    checkOutput("match beats W1C", dmRData, 32'h1);
    applyStimulus(A_TSTAT, 1'b1, 32'h1);
    checkOutput("match W1C clears", dmRData, 32'h0);

    $display("[TB] counter wrap");
    applyStimulus(A_TCTRL, 1'b1, 32'h0);
    applyStimulus(A_TCNT, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(A_TCMP, 1'b1, 32'd5);
    applyStimulus(A_TSTAT, 1'b1, 32'h1);
    applyStimulus(A_TCTRL, 1'b1, 32'h1);
    applyStimulus(A_TCNT, 1'b0, 32'h0);
    checkOutput("TCNT wrap", dmRData, 32'h0);
    applyStimulus(A_TSTAT, 1'b0, 32'h0);
    checkOutput("no match on wrap", dmRData, 32'h0);

    applyStimulus(A_TCTRL, 1'b1, 32'h0);
    applyStimulus(A_TCNT, 1'b1, 32'h0);
    applyStimulus(A_TCMP, 1'b1, 32'd2);
    applyStimulus(A_TCTRL, 1'b1, 32'h5);
    for (int i = 0; i < 20 && irq !== 1'b1; i++)
      applyStimulus(A_TCNT, 1'b0, 32'h0);
    checkOutput("irq before reset", {31'b0, irq}, 32'h1);
`else
    $display("[TB] timer absent");
    applyStimulus(A_TCNT, 1'b1, 32'hFFFF_FFFF);
    checkOutput("TCNT absent", dmRData, 32'h0);
    applyStimulus(A_TCMP, 1'b1, 32'hFFFF_FFFF);
    checkOutput("TCMP absent", dmRData, 32'h0);
    applyStimulus(A_TCTRL, 1'b1, 32'hFFFF_FFFF);
    checkOutput("TCTRL absent", dmRData, 32'h0);
    applyStimulus(A_TSTAT, 1'b0, 32'h0);
    checkOutput("TSTAT no match bit", dmRData, 32'h0);
    checkOutput("irq tied low", {31'b0, irq}, 32'h0);
`endif

    $display("[TB] asynchronous reset mid-operation");
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async reset irq", {31'b0, irq}, 32'h0);
    checkOutput("async reset gpioOut", {16'b0, gpioOut}, 32'h0);
    peek(A_TCNT);
    checkOutput("async reset TCNT", dmRData, 32'h0);
    dmAddr = 32'h0000_0020; dmWe = 1'b1; dmWData = 32'h0000_0055;
    @(posedge clk);
    #1;
    dmWe = 1'b0;
    #2;
    rst = 1'b0;
    modelReset();
    peek(32'h0000_0020);
    checkOutput("write lost in reset", dmRData, 32'hAAAA_5555);
    peek(32'h0000_0010);
    checkOutput("RAM kept over reset", dmRData, 32'hDEAD_BEEF);

    $display("[TB] randomized run");
    for (int i = 0; i < 8; i++)
      applyStimulus(32'(i * 4), 1'b1, $urandom);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] wd;
      int kind = $urandom_range(0, 9);
      if (kind < 4)
        a = {4'h0, 22'($urandom), 4'($urandom_range(0, 7)), 2'b00};
      else if (kind < 9)
        a = {4'hF, 22'($urandom), 4'($urandom_range(0, 15)), 2'b00};
      else
        a = {4'($urandom_range(1, 14)), 28'($urandom)};
      wd = $urandom;
      if (a[31:28] == 4'hF && (a[5:2] == 4'd2 || a[5:2] == 4'd3))
        wd = 32'($urandom_range(0, 12));
      gpioIn = 16'($urandom);
      applyStimulus(a, 1'($urandom_range(0, 1)), wd);
      checkModel("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
